lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_neuron.sv | 120 ++++++++++++
 tb/tb_lif_neuron.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weighted input spikes with a
// periodic shift-based leak, fires on threshold, then holds a refractory period.
module lif_neuron #(
    parameter int LEAK_PERIOD    = 4,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRACT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_spike,
    input  logic [7:0] weight,
    input  logic [7:0] threshold,
    input  logic       count_clr,
    output logic       post_spike,
    output logic [7:0] membrane,
    output logic       refractory,
    output logic [7:0] spike_count
);

    typedef enum logic {S_INTEGRATE = 1'b0, S_REFRACT = 1'b1} state_e;

    localparam logic [7:0] LEAK_LAST    = 8'(LEAK_PERIOD - 1);
    localparam logic [7:0] REFRACT_INIT = 8'(REFRACT_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] membrane_q, membrane_d;
    logic       post_spike_q, post_spike_d;
    logic [7:0] spike_count_q, spike_count_d;
    logic [7:0] leak_cnt_q, leak_cnt_d;
    logic [7:0] refract_cnt_q, refract_cnt_d;

    logic       leak_evt;
    logic [7:0] v_leak;
    logic [7:0] v;
    logic       fire;

    // Subtracting a right-shifted copy of itself can never go below zero.
    function automatic logic [7:0] apply_leak(input logic [7:0] m);
        return m - (m >> LEAK_SHIFT);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign leak_evt = (leak_cnt_q == LEAK_LAST);
    assign v_leak   = leak_evt ? apply_leak(membrane_q) : membrane_q;
    assign v        = pre_spike ? sat_add(v_leak, weight) : v_leak;
    assign fire     = (state_q == S_INTEGRATE) && (threshold != 8'd0) && (v >= threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INTEGRATE;
            membrane_q    <= 8'd0;
            post_spike_q  <= 1'b0;
            spike_count_q <= 8'd0;
            leak_cnt_q    <= 8'd0;
            refract_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            membrane_q    <= membrane_d;
            post_spike_q  <= post_spike_d;
            spike_count_q <= spike_count_d;
            leak_cnt_q    <= leak_cnt_d;
            refract_cnt_q <= refract_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INTEGRATE: if (fire) state_d = S_REFRACT;
            S_REFRACT:   if (refract_cnt_q <= 8'd1) state_d = S_INTEGRATE;
            default:     state_d = S_INTEGRATE;
        endcase
    end

    always_comb begin
        membrane_d    = membrane_q;
        post_spike_d  = 1'b0;
        leak_cnt_d    = leak_cnt_q;
        refract_cnt_d = refract_cnt_q;
        case (state_q)
            S_INTEGRATE: begin
                if (fire) begin
                    membrane_d    = 8'd0;
                    post_spike_d  = 1'b1;
                    leak_cnt_d    = 8'd0;
                    refract_cnt_d = REFRACT_INIT;
                end else begin
                    membrane_d = v;
                    leak_cnt_d = leak_evt ? 8'd0 : leak_cnt_q + 8'd1;
                end
            end
            default: begin
                membrane_d    = 8'd0;
                leak_cnt_d    = 8'd0;
                refract_cnt_d = (refract_cnt_q != 8'd0) ? refract_cnt_q - 8'd1 : 8'd0;
            end
        endcase
    end

    // A fire coinciding with a clear leaves exactly that one fire counted.
    always_comb begin
        spike_count_d = spike_count_q;
        if (count_clr) begin
            spike_count_d = fire ? 8'd1 : 8'd0;
        end else if (fire && spike_count_q != 8'hFF) begin
            spike_count_d = spike_count_q + 8'd1;
        end
    end

    assign post_spike  = post_spike_q;
    assign membrane    = membrane_q;
    assign refractory  = (state_q == S_REFRACT);
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron with default parameters.
module tb_lif_neuron;

    logic       clk;
    logic       rst_n;
    logic       pre_spike;
    logic [7:0] weight;
    logic [7:0] threshold;
    logic       count_clr;
    logic       post_spike;
    logic [7:0] membrane;
    logic       refractory;
    logic [7:0] spike_count;

    int n_cmp = 0;
    int n_bad = 0;

    lif_neuron dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .weight     (weight),
        .threshold  (threshold),
        .count_clr  (count_clr),
        .post_spike (post_spike),
        .membrane   (membrane),
        .refractory (refractory),
        .spike_count(spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        pre_spike = 1'b0;
        count_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        pre_spike = 1'b1;
        weight    = 8'd255;
        threshold = 8'd64;
        count_clr = 1'b0;
        repeat (3) step();
        n_cmp++; if (membrane !== 8'd0) begin n_bad++; $display("FAIL reset_membrane got=%0d exp=0", membrane); end
        n_cmp++; if (post_spike !== 1'b0) begin n_bad++; $display("FAIL reset_post got=%b exp=0", post_spike); end
        n_cmp++; if (refractory !== 1'b0) begin n_bad++; $display("FAIL reset_refr got=%b exp=0", refractory); end
        n_cmp++; if (spike_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", spike_count); end
    endtask

    task automatic test_fire_refract();
        do_reset();
        threshold = 8'd64;
        weight    = 8'd32;
        pre_spike = 1'b1;
        step();
        n_cmp++; if (membrane !== 8'd32) begin n_bad++; $display("FAIL fire_e1_membrane got=%0d exp=32", membrane); end
        n_cmp++; if (post_spike !== 1'b0) begin n_bad++; $display("FAIL fire_e1_post got=%b exp=0", post_spike); end
        step();
        n_cmp++; if (post_spike !== 1'b1) begin n_bad++; $display("FAIL fire_e2_post got=%b exp=1", post_spike); end
        n_cmp++; if (membrane !== 8'd0) begin n_bad++; $display("FAIL fire_e2_membrane got=%0d exp=0", membrane); end
        n_cmp++; if (refractory !== 1'b1) begin n_bad++; $display("FAIL fire_e2_refr got=%b exp=1", refractory); end
        n_cmp++; if (spike_count !== 8'd1) begin n_bad++; $display("FAIL fire_e2_count got=%0d exp=1", spike_count); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (refractory !== 1'b1) begin n_bad++; $display("FAIL refr_hold%0d got=%b exp=1", i, refractory); end
            n_cmp++; if (membrane !== 8'd0) begin n_bad++; $display("FAIL refr_membrane%0d got=%0d exp=0", i, membrane); end
            n_cmp++; if (post_spike !== 1'b0) begin n_bad++; $display("FAIL refr_post%0d got=%b exp=0", i, post_spike); end
        end
        step();
        n_cmp++; if (refractory !== 1'b0) begin n_bad++; $display("FAIL refr_exit got=%b exp=0", refractory); end
        n_cmp++; if (membrane !== 8'd0) begin n_bad++; $display("FAIL refr_exit_membrane got=%0d exp=0", membrane); end
        step();
        n_cmp++; if (membrane !== 8'd32) begin n_bad++; $display("FAIL first_integrate got=%0d exp=32", membrane); end
        n_cmp++; if (spike_count !== 8'd1) begin n_bad++; $display("FAIL fire_count_hold got=%0d exp=1", spike_count); end
        pre_spike = 1'b0;
    endtask

    task automatic test_leak();
        do_reset();
        threshold = 8'd200;
        weight    = 8'd100;
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        n_cmp++; if (membrane !== 8'd100) begin n_bad++; $display("FAIL leak_e1 got=%0d exp=100", membrane); end
        repeat (2) step();
        n_cmp++; if (membrane !== 8'd100) begin n_bad++; $display("FAIL leak_e3 got=%0d exp=100", membrane); end
        step();
        n_cmp++; if (membrane !== 8'd50) begin n_bad++; $display("FAIL leak_e4 got=%0d exp=50", membrane); end
        repeat (4) step();
        n_cmp++; if (membrane !== 8'd25) begin n_bad++; $display("FAIL leak_e8 got=%0d exp=25", membrane); end
    endtask

    task automatic test_sat_disable();
        logic seen;
        seen = 1'b0;
        do_reset();
        threshold = 8'd0;
        weight    = 8'd200;
        pre_spike = 1'b1;
        step();
        seen |= post_spike;
        n_cmp++; if (membrane !== 8'd200) begin n_bad++; $display("FAIL sat_e1 got=%0d exp=200", membrane); end
        step();
        seen |= post_spike;
        pre_spike = 1'b0;
        n_cmp++; if (membrane !== 8'd255) begin n_bad++; $display("FAIL sat_e2 got=%0d exp=255", membrane); end
        repeat (6) begin
            step();
            seen |= post_spike;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL disable_post got=%b exp=0", seen); end
    endtask

    task automatic test_threshold_change();
        do_reset();
        threshold = 8'd200;
        weight    = 8'd32;
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        threshold = 8'd20;
        step();
        n_cmp++; if (post_spike !== 1'b1) begin n_bad++; $display("FAIL thr_change_post got=%b exp=1", post_spike); end
        n_cmp++; if (membrane !== 8'd0) begin n_bad++; $display("FAIL thr_change_membrane got=%0d exp=0", membrane); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        threshold = 8'd64;
        weight    = 8'd64;
        pre_spike = 1'b1;
        step();
        n_cmp++; if (post_spike !== 1'b1) begin n_bad++; $display("FAIL mid_fire got=%b exp=1", post_spike); end
        step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (refractory !== 1'b0) begin n_bad++; $display("FAIL mid_rst_refr got=%b exp=0", refractory); end
        n_cmp++; if (membrane !== 8'd0) begin n_bad++; $display("FAIL mid_rst_membrane got=%0d exp=0", membrane); end
        n_cmp++; if (spike_count !== 8'd0) begin n_bad++; $display("FAIL mid_rst_count got=%0d exp=0", spike_count); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (post_spike !== 1'b1) begin n_bad++; $display("FAIL post_rst_first_edge got=%b exp=1", post_spike); end
        n_cmp++; if (spike_count !== 8'd1) begin n_bad++; $display("FAIL post_rst_count got=%0d exp=1", spike_count); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (post_spike !== 1'b0) begin n_bad++; $display("FAIL mid_pulse_rst got=%b exp=0", post_spike); end
        @(negedge clk);
        rst_n     = 1'b1;
        pre_spike = 1'b0;
    endtask

    task automatic test_count();
        do_reset();
        threshold = 8'd1;
        weight    = 8'd1;
        pre_spike = 1'b1;
        // One fire every 4 edges starting at edge 1: 300 fires in 1200 edges.
        repeat (1200) step();
        n_cmp++; if (spike_count !== 8'd255) begin n_bad++; $display("FAIL count_sat got=%0d exp=255", spike_count); end
        n_cmp++; if (refractory !== 1'b0) begin n_bad++; $display("FAIL count_phase got=%b exp=0", refractory); end
        count_clr = 1'b1;
        step();
        n_cmp++; if (post_spike !== 1'b1) begin n_bad++; $display("FAIL clr_fire_post got=%b exp=1", post_spike); end
        n_cmp++; if (spike_count !== 8'd1) begin n_bad++; $display("FAIL clr_with_fire got=%0d exp=1", spike_count); end
        step();
        n_cmp++; if (spike_count !== 8'd0) begin n_bad++; $display("FAIL clr_plain got=%0d exp=0", spike_count); end
        count_clr = 1'b0;
        pre_spike = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fire_refract();
        test_leak();
        test_sat_disable();
        test_threshold_change();
        test_reset_mid();
        test_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
